// File: rtl/riscv_pkg.sv
// Shared pipeline types for the memory stage.
// Bus FSM states, funct3 access codes, result-select codes.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        RESP
    } mem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RS_ALU = 2'b00;
    localparam logic [1:0] RS_MEM = 2'b01;
    localparam logic [1:0] RS_PC4 = 2'b10;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, extraction/extension for loads,
// and detection of misaligned or illegal accesses.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic        store_i,
    input  logic        load_i,
    input  logic [31:0] wd_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o,
    output logic        err_o
);

    logic [31:0] shifted;
    logic        illegal;
    logic        misal;

    assign shifted = rdata_i >> {off_i, 3'b000};

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = wd_i;
        ldata_o = '0;
        illegal = 1'b0;
        misal   = 1'b0;
        case (funct3_i)
            F3_B: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wd_i[7:0]}};
                ldata_o = {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_H: begin
                be_o    = 4'b0011 << off_i;
                wdata_o = {2{wd_i[15:0]}};
                ldata_o = {{16{shifted[15]}}, shifted[15:0]};
                misal   = off_i[0];
            end
            F3_W: begin
                be_o    = 4'b1111;
                ldata_o = shifted;
                misal   = |off_i;
            end
            F3_BU: begin
                ldata_o = {24'd0, shifted[7:0]};
                illegal = store_i;
            end
            F3_HU: begin
                ldata_o = {16'd0, shifted[15:0]};
                misal   = off_i[0];
                illegal = store_i;
            end
            default: illegal = 1'b1;
        endcase
        // Loads always fetch the whole word.
        if (!store_i) be_o = 4'b0000;
        err_o = (store_i | load_i) & (illegal | misal);
    end

endmodule

// File: rtl/memory_cycle.sv
// Memory stage: drives the data bus for loads/stores, stalls while
// an access is outstanding, and feeds the MEM/WB register.
module memory_cycle
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        regwriteM,
    input  logic [1:0]  resultsrcM,
    input  logic        memwriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] aluresultM,
    input  logic [31:0] writedataM,
    input  logic [31:0] pcplus4M,
    input  logic [4:0]  rdM,
    output logic        dreq_valid,
    input  logic        dreq_ready,
    output logic        dreq_we,
    output logic [31:0] dreq_addr,
    output logic [31:0] dreq_wdata,
    output logic [3:0]  dreq_be,
    input  logic        dresp_valid,
    input  logic [31:0] dresp_rdata,
    output logic        stallM,
    output logic        errM,
    output logic        regwriteW,
    output logic [1:0]  resultsrcW,
    output logic [31:0] aluresultW,
    output logic [31:0] readdataW,
    output logic [31:0] pcplus4W,
    output logic [4:0]  rdW
);

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

    mem_state_t  state_q;
    logic [31:0] cnt_q;

    logic        is_st;
    logic        is_ld;
    logic        acc;
    logic        err;
    logic        bad;
    logic        req;
    logic        hs;
    logic        rsp;
    logic        tmo;
    logic        done;
    logic [31:0] ldata;

    assign is_st = memwriteM;
    assign is_ld = (resultsrcM == RS_MEM) & ~memwriteM;
    assign acc   = is_st | is_ld;

    lsu_align u_align (
        .funct3_i (funct3M),
        .off_i    (aluresultM[1:0]),
        .store_i  (is_st),
        .load_i   (is_ld),
        .wd_i     (writedataM),
        .rdata_i  (dresp_rdata),
        .be_o     (dreq_be),
        .wdata_o  (dreq_wdata),
        .ldata_o  (ldata),
        .err_o    (err)
    );

    assign bad = (state_q == IDLE) & acc & err;
    assign req = ((state_q == IDLE) & acc & ~err) | (state_q == ADDR);
    assign hs  = req & dreq_ready;
    assign rsp = (state_q == RESP) & dresp_valid;

    // Abort on the last allowed wait cycle that made no progress.
    assign tmo = (TIMEOUT_CYCLES != 0)
               & ((state_q == ADDR) | (state_q == RESP))
               & ~hs & ~rsp & (cnt_q == TO_LAST);

    assign done = (hs & is_st) | rsp | tmo;

    assign dreq_valid = req;
    assign dreq_we    = memwriteM;
    assign dreq_addr  = {aluresultM[31:2], 2'b00};
    assign stallM     = acc & ~err & ~done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            errM       <= 1'b0;
            regwriteW  <= 1'b0;
            resultsrcW <= RS_ALU;
            aluresultW <= '0;
            readdataW  <= '0;
            pcplus4W   <= '0;
            rdW        <= '0;
        end else begin
            errM <= bad | tmo;

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (acc && !err) begin
                        if (!hs)        state_q <= ADDR;
                        else if (is_ld) state_q <= RESP;
                    end
                end
                ADDR: begin
                    if (hs) begin
                        cnt_q   <= '0;
                        state_q <= is_st ? IDLE : RESP;
                    end else if (tmo) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                RESP: begin
                    if (rsp || tmo) state_q <= IDLE;
                    else            cnt_q   <= cnt_q + 32'd1;
                end
                default: state_q <= IDLE;
            endcase

            if (stallM) begin
                regwriteW  <= 1'b0;
                resultsrcW <= RS_ALU;
                aluresultW <= '0;
                readdataW  <= '0;
                pcplus4W   <= '0;
                rdW        <= '0;
            end else begin
                regwriteW  <= regwriteM & ~bad & ~tmo;
                resultsrcW <= resultsrcM;
                aluresultW <= aluresultM;
                readdataW  <= rsp ? ldata : 32'd0;
                pcplus4W   <= pcplus4M;
                rdW        <= rdM;
            end
        end
    end

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for the memory stage: ALU pass-through, stores,
// loads with bus wait states, error pulses, timeout and reset abort.
module tb_memory_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        regwriteM;
    logic [1:0]  resultsrcM;
    logic        memwriteM;
    logic [2:0]  funct3M;
    logic [31:0] aluresultM;
    logic [31:0] writedataM;
    logic [31:0] pcplus4M;
    logic [4:0]  rdM;
    logic        dreq_valid;
    logic        dreq_ready;
    logic        dreq_we;
    logic [31:0] dreq_addr;
    logic [31:0] dreq_wdata;
    logic [3:0]  dreq_be;
    logic        dresp_valid;
    logic [31:0] dresp_rdata;
    logic        stallM;
    logic        errM;
    logic        regwriteW;
    logic [1:0]  resultsrcW;
    logic [31:0] aluresultW;
    logic [31:0] readdataW;
    logic [31:0] pcplus4W;
    logic [4:0]  rdW;

    int n_err = 0;
    int n_chk = 0;

    memory_cycle #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .regwriteM   (regwriteM),
        .resultsrcM  (resultsrcM),
        .memwriteM   (memwriteM),
        .funct3M     (funct3M),
        .aluresultM  (aluresultM),
        .writedataM  (writedataM),
        .pcplus4M    (pcplus4M),
        .rdM         (rdM),
        .dreq_valid  (dreq_valid),
        .dreq_ready  (dreq_ready),
        .dreq_we     (dreq_we),
        .dreq_addr   (dreq_addr),
        .dreq_wdata  (dreq_wdata),
        .dreq_be     (dreq_be),
        .dresp_valid (dresp_valid),
        .dresp_rdata (dresp_rdata),
        .stallM      (stallM),
        .errM        (errM),
        .regwriteW   (regwriteW),
        .resultsrcW  (resultsrcW),
        .aluresultW  (aluresultW),
        .readdataW   (readdataW),
        .pcplus4W    (pcplus4W),
        .rdW         (rdW)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic instr(input logic rw, input logic [1:0] rs,
                         input logic mw, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] rd);
        regwriteM  = rw;
        resultsrcM = rs;
        memwriteM  = mw;
        funct3M    = f3;
        aluresultM = alu;
        writedataM = wd;
        pcplus4M   = 32'h1000 + {27'd0, rd};
        rdM        = rd;
    endtask

    task automatic nop();
        instr(1'b0, 2'b00, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
        pcplus4M = 32'd0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        dreq_ready  = 1'b0;
        dresp_valid = 1'b0;
        dresp_rdata = 32'd0;
        nop();
        step();
        step();
        chk("rst_valid", {31'd0, dreq_valid}, 32'd0);
        chk("rst_stall", {31'd0, stallM}, 32'd0);
        chk("rst_err", {31'd0, errM}, 32'd0);
        chk("rst_rw", {31'd0, regwriteW}, 32'd0);
        chk("rst_rd", {27'd0, rdW}, 32'd0);
        chk("rst_rdata", readdataW, 32'd0);
        rst = 1'b0;

        // ALU op passes through in one cycle
        instr(1'b1, 2'b00, 1'b0, 3'b000, 32'h1234, 32'd0, 5'd5);
        #1;
        chk("alu_stall", {31'd0, stallM}, 32'd0);
        chk("alu_valid", {31'd0, dreq_valid}, 32'd0);
        step();
        chk("alu_res", aluresultW, 32'h1234);
        chk("alu_rd", {27'd0, rdW}, 32'd5);
        chk("alu_rw", {31'd0, regwriteW}, 32'd1);
        chk("alu_pc4", pcplus4W, 32'h1005);

        // SB at 0x103, bus ready at once
        instr(1'b0, 2'b00, 1'b1, 3'b000, 32'h103, 32'hAB, 5'd0);
        dreq_ready = 1'b1;
        #1;
        chk("sb_valid", {31'd0, dreq_valid}, 32'd1);
        chk("sb_we", {31'd0, dreq_we}, 32'd1);
        chk("sb_be", {28'd0, dreq_be}, 32'h8);
        chk("sb_wdata", dreq_wdata, 32'hABABABAB);
        chk("sb_addr", dreq_addr, 32'h100);
        chk("sb_stall", {31'd0, stallM}, 32'd0);
        step();
        dreq_ready = 1'b0;
        chk("sb_rw", {31'd0, regwriteW}, 32'd0);
        chk("sb_err", {31'd0, errM}, 32'd0);

        // SH at 0x102, one wait state, completes from ADDR
        instr(1'b0, 2'b00, 1'b1, 3'b001, 32'h102, 32'h1234BEEF, 5'd0);
        #1;
        chk("sh_stall0", {31'd0, stallM}, 32'd1);
        step();
        dreq_ready = 1'b1;
        #1;
        chk("sh_valid1", {31'd0, dreq_valid}, 32'd1);
        chk("sh_be", {28'd0, dreq_be}, 32'hC);
        chk("sh_wdata", dreq_wdata, 32'hBEEFBEEF);
        chk("sh_stall1", {31'd0, stallM}, 32'd0);
        step();
        dreq_ready = 1'b0;
        nop();
        #1;
        chk("sh_idle", {31'd0, dreq_valid}, 32'd0);

        // LB at 0x202: ready after 2 cycles, response 1 later
        instr(1'b1, 2'b01, 1'b0, 3'b000, 32'h202, 32'd0, 5'd7);
        #1;
        chk("lb_valid0", {31'd0, dreq_valid}, 32'd1);
        chk("lb_be", {28'd0, dreq_be}, 32'd0);
        chk("lb_addr", dreq_addr, 32'h200);
        chk("lb_stall0", {31'd0, stallM}, 32'd1);
        step();
        dresp_valid = 1'b1;
        dresp_rdata = 32'hFFFFFFFF;
        #1;
        chk("lb_stall1", {31'd0, stallM}, 32'd1);
        chk("lb_bub_rw", {31'd0, regwriteW}, 32'd0);
        chk("lb_bub_rd", {27'd0, rdW}, 32'd0);
        step();
        dresp_valid = 1'b0;
        dreq_ready  = 1'b1;
        #1;
        chk("lb_stall2", {31'd0, stallM}, 32'd1);
        chk("lb_bub_rdata", readdataW, 32'd0);
        step();
        dreq_ready  = 1'b0;
        dresp_valid = 1'b1;
        dresp_rdata = 32'h00800000;
        #1;
        chk("lb_stall3", {31'd0, stallM}, 32'd0);
        chk("lb_valid3", {31'd0, dreq_valid}, 32'd0);
        step();
        dresp_valid = 1'b0;
        nop();
        chk("lb_data", readdataW, 32'hFFFFFF80);
        chk("lb_rw", {31'd0, regwriteW}, 32'd1);
        chk("lb_rd", {27'd0, rdW}, 32'd7);
        chk("lb_rs", {30'd0, resultsrcW}, 32'd1);

        // LBU, same data, ready at once
        instr(1'b1, 2'b01, 1'b0, 3'b100, 32'h202, 32'd0, 5'd8);
        dreq_ready = 1'b1;
        #1;
        chk("lbu_stall0", {31'd0, stallM}, 32'd1);
        step();
        dreq_ready  = 1'b0;
        dresp_valid = 1'b1;
        dresp_rdata = 32'h00800000;
        #1;
        chk("lbu_stall1", {31'd0, stallM}, 32'd0);
        step();
        dresp_valid = 1'b0;
        nop();
        chk("lbu_data", readdataW, 32'h00000080);

        // LH at 0x206, upper half negative
        instr(1'b1, 2'b01, 1'b0, 3'b001, 32'h206, 32'd0, 5'd9);
        dreq_ready = 1'b1;
        step();
        dreq_ready  = 1'b0;
        dresp_valid = 1'b1;
        dresp_rdata = 32'h80010000;
        step();
        dresp_valid = 1'b0;
        nop();
        chk("lh_data", readdataW, 32'hFFFF8001);

        // LW at 0x302 is misaligned
        instr(1'b1, 2'b01, 1'b0, 3'b010, 32'h302, 32'd0, 5'd9);
        dreq_ready = 1'b1;
        #1;
        chk("lwm_valid", {31'd0, dreq_valid}, 32'd0);
        chk("lwm_stall", {31'd0, stallM}, 32'd0);
        step();
        dreq_ready = 1'b0;
        nop();
        chk("lwm_err", {31'd0, errM}, 32'd1);
        chk("lwm_rw", {31'd0, regwriteW}, 32'd0);
        step();
        chk("lwm_err_end", {31'd0, errM}, 32'd0);

        // store with funct3=100 is illegal
        instr(1'b0, 2'b00, 1'b1, 3'b100, 32'h100, 32'h55, 5'd0);
        #1;
        chk("sill_valid", {31'd0, dreq_valid}, 32'd0);
        step();
        nop();
        chk("sill_err", {31'd0, errM}, 32'd1);

        // LW at 0x400, response withheld until timeout
        instr(1'b1, 2'b01, 1'b0, 3'b010, 32'h400, 32'd0, 5'd3);
        dreq_ready = 1'b1;
        #1;
        chk("to_stall0", {31'd0, stallM}, 32'd1);
        step();
        dreq_ready = 1'b0;
        #1;
        chk("to_stall1", {31'd0, stallM}, 32'd1);
        step();
        chk("to_stall2", {31'd0, stallM}, 32'd1);
        step();
        chk("to_stall3", {31'd0, stallM}, 32'd1);
        chk("to_err_early", {31'd0, errM}, 32'd0);
        step();
        chk("to_stall4", {31'd0, stallM}, 32'd0);
        step();
        nop();
        dresp_valid = 1'b1;
        dresp_rdata = 32'hDEADBEEF;
        chk("to_err", {31'd0, errM}, 32'd1);
        chk("to_rw", {31'd0, regwriteW}, 32'd0);
        step();
        dresp_valid = 1'b0;
        chk("to_late", readdataW, 32'd0);
        chk("to_err_end", {31'd0, errM}, 32'd0);

        // reset while waiting in RESP
        instr(1'b1, 2'b01, 1'b0, 3'b010, 32'h500, 32'd0, 5'd4);
        dreq_ready = 1'b1;
        step();
        dreq_ready = 1'b0;
        #1;
        chk("rr_stall", {31'd0, stallM}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        nop();
        dresp_valid = 1'b1;
        dresp_rdata = 32'h12345678;
        #1;
        chk("rr_stall_after", {31'd0, stallM}, 32'd0);
        chk("rr_valid", {31'd0, dreq_valid}, 32'd0);
        chk("rr_rw", {31'd0, regwriteW}, 32'd0);
        chk("rr_rdata", readdataW, 32'd0);
        step();
        dresp_valid = 1'b0;
        chk("rr_stray", readdataW, 32'd0);
        chk("rr_err", {31'd0, errM}, 32'd0);

        // PC+4 result select passes through
        instr(1'b1, 2'b10, 1'b0, 3'b000, 32'h77, 32'd0, 5'd1);
        step();
        chk("pc4_rs", {30'd0, resultsrcW}, 32'd2);
        chk("pc4_val", pcplus4W, 32'h1001);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/memory_cycle.md
Name: memory_cycle

Overview:
- Memory stage of the 5-stage RISC-V pipeline.
- Consumes the EX/MEM register outputs, performs loads and stores over a valid/ready data-bus interface, and stalls the pipeline while an access is outstanding.
- Drives the MEM/WB register (W-side signals) consumed by the writeback mux and the forwarding unit.
- Handles LB/LH/LW/LBU/LHU/SB/SH/SW alignment and sign extension, and flags misaligned or illegal accesses.

Parameters:
- TIMEOUT_CYCLES, 0, max cycles waiting on dreq_ready or dresp_valid before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- regwriteM  in  1  register write enable from EX/MEM
- resultsrcM  in  2  result select: 00 ALU, 01 load, 10 PC+4
- memwriteM  in  1  store enable
- funct3M  in  3  access size/sign
- aluresultM  in  32  effective address or ALU result
- writedataM  in  32  store data (already forwarded)
- pcplus4M  in  32  PC+4
- rdM  in  5  destination register
- dreq_valid  out  1  bus request valid
- dreq_ready  in  1  bus accepts request
- dreq_we  out  1  1 = write
- dreq_addr  out  32  word-aligned address ({aluresultM[31:2], 2'b00})
- dreq_wdata  out  32  lane-replicated store data
- dreq_be  out  4  byte enables
- dresp_valid  in  1  read data valid
- dresp_rdata  in  32  read word
- stallM  out  1  freeze F/D/E/M registers
- errM  out  1  one-cycle pulse: misaligned, illegal funct3 or timeout
- regwriteW  out  1  MEM/WB register write enable
- resultsrcW  out  2  MEM/WB result select
- aluresultW  out  32  MEM/WB ALU result
- readdataW  out  32  MEM/WB extended load data
- pcplus4W  out  32  MEM/WB PC+4
- rdW  out  5  MEM/WB destination register

Behaviour:
- Access condition: acc = memwriteM | (resultsrcM==01). Non-access instructions pass through in 1 cycle with no stall.
- Legal funct3 values:
  - loads 000, 001, 010, 100, 101
  - stores 000, 001, 010
- Error conditions:
  - misaligned halfword: addr[0]=1
  - misaligned word: addr[1:0]!=0
  - illegal funct3
  - On error: no bus request, errM=1 for one cycle, and MEM/WB captures the instruction with regwriteW=0; no stall.
- FSM states: IDLE, ADDR, RESP.
  - IDLE, legal acc: dreq_valid=1 combinationally, go to ADDR behaviour in the same cycle.
  - Handshake cycle (dreq_valid & dreq_ready):
    - stores complete that cycle (stallM=0) and stay in IDLE;
    - loads go to RESP.
  - No handshake: go to ADDR; dreq_valid held until ready. Request fields must not change while valid and not ready; the stall guarantees stable inputs.
  - RESP: wait for dresp_valid. The response arrives at earliest 1 cycle after the handshake. The completion cycle has stallM=0, MEM/WB captures the extended data, and the FSM returns to IDLE.
  - dresp_valid in IDLE or ADDR is ignored.
- stallM = acc & legal & ~completing_this_cycle. While stallM=1 the MEM/WB register loads a bubble: regwriteW=0, rdW=0, and other fields 0.
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata={4{wd[7:0]}}
  - SH: be=0011<<addr[1:0], wdata={2{wd[15:0]}}
  - SW: be=1111
  - dreq_be=0 for loads (read whole word).
- Load extraction: select byte/half by addr[1:0]; sign-extend for 000/001, zero-extend for 100/101.
- Timeout (TIMEOUT_CYCLES>0): counter cleared on entering ADDR/RESP and incremented each waiting cycle. Reaching TIMEOUT_CYCLES causes:
  - errM pulse and return to IDLE;
  - stallM=0 and instruction retired with regwriteW=0;
  - a late dresp_valid is ignored.
- Reset: FSM to IDLE, counter 0, dreq_valid=0, stallM=0, errM=0, and all W outputs 0. Reset mid-access abandons it; a subsequent stray dresp_valid is ignored.

Decomposition:
- Shared package riscv_pkg:
  - mem_state_t enum (IDLE, ADDR, RESP)
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - resultsrc constants RS_ALU, RS_MEM, RS_PC4
- One combinational sub-module, lsu_align: store lane/byte-enable generation, load extraction/extension, misalignment/illegal detection.

Test Plan:
- ALU op (resultsrcM=00, regwriteM=1, aluresultM=0x1234, rdM=5) -> next cycle aluresultW=0x1234, rdW=5, regwriteW=1, stallM never asserted.
- SB addr 0x103, wd 0xAB, dreq_ready=1 immediately -> dreq_be=1000, dreq_wdata=0xABABABAB, dreq_addr=0x100, stallM=0.
- LB addr 0x202, dreq_ready after 2 cycles, dresp 1 cycle later with rdata 0x00800000 -> stallM high 3 cycles, readdataW=0xFFFFFF80; same with LBU -> 0x00000080.
- LW addr 0x302 -> errM pulse, dreq_valid never 1, regwriteW=0, no stall.
- TIMEOUT_CYCLES=4, LW with dresp_valid withheld -> errM after 4 wait cycles, stallM drops, late dresp_valid ignored.
- rst asserted in RESP -> next cycle IDLE, all outputs 0; a following dresp_valid does not change readdataW.
